sprite_anim_renderer: RTL and testbench

- Positioned, animated successor to the full-screen sprite ROM example.
- Places a W×H palettised sprite sheet of NUM_FRAMES frames at a latched screen position, with integer upscale and optional horizontal mirroring.
- Steps animation frames on vertical-frame ticks under a play/loop/hold state machine.
- Drives an external synchronous sprite ROM and outputs a palette index plus an opaque-pixel flag to the screen compositor; palette lookup stays outside this block.

---
 rtl/sprite_anim_renderer.sv | 205 ++++++++++++++++++++
 tb/tb_sprite_anim_renderer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_anim_renderer.sv
// sprite_anim_renderer: places an animated, palettised sprite sheet at a
// latched screen position with integer upscale and optional mirroring. It
// drives an external synchronous sprite ROM and outputs a palette index plus
// an opaque-pixel flag. Palette lookup stays outside this block.
//
// Pixel pipeline qualifier: pixel_valid is a pure qualifier with no
// back-pressure. When it is 1, pixel_index holds the opaque palette index of a
// sprite texel for the pixel presented on DrawX/DrawY two vga_clk edges
// earlier, inside the active region. When it is 0, pixel_index carries no
// meaning and the compositor shows the background.
module sprite_anim_renderer #(
   parameter int SPR_W           = 70,
   parameter int SPR_H           = 160,
   parameter int NUM_FRAMES      = 4,
   parameter int IDX_BITS        = 3,
   parameter int ADDR_W          = 16,
   parameter int SCALE_LOG2      = 0,
   parameter int FRAME_TICKS     = 6,
   parameter int TRANSPARENT_IDX = 0,
   localparam int FRAME_W        = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
   input  logic                vga_clk,
   input  logic                reset,
   input  logic [9:0]          DrawX,
   input  logic [9:0]          DrawY,
   input  logic                blank,
   input  logic                frame_tick,
   input  logic [9:0]          pos_x,
   input  logic [9:0]          pos_y,
   input  logic                flip_x,
   input  logic                trigger,
   input  logic                loop_en,
   output logic [ADDR_W-1:0]   rom_address,
   input  logic [IDX_BITS-1:0] rom_q,
   output logic [IDX_BITS-1:0] pixel_index,
   output logic                pixel_valid,
   output logic [FRAME_W-1:0]  anim_frame,
   output logic                anim_done,
   output logic [1:0]          dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam int CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

   localparam logic [10:0]         SPAN_X       = 11'(SPR_W << SCALE_LOG2);
   localparam logic [10:0]         SPAN_Y       = 11'(SPR_H << SCALE_LOG2);
   localparam logic [10:0]         COL_MAX      = 11'(SPR_W - 1);
   localparam logic [ADDR_W-1:0]   FRAME_SIZE_A = ADDR_W'(SPR_W * SPR_H);
   localparam logic [ADDR_W-1:0]   SPR_W_A      = ADDR_W'(SPR_W);
   localparam logic [CNT_W-1:0]    LAST_TICK    = CNT_W'(FRAME_TICKS - 1);
   localparam logic [FRAME_W-1:0]  LAST_FRAME   = FRAME_W'(NUM_FRAMES - 1);
   localparam logic [IDX_BITS-1:0] TRANS_IDX    = IDX_BITS'(TRANSPARENT_IDX);

   // Animation state
   state_t               state_q;
   logic [FRAME_W-1:0]   anim_frame_q;
   logic [CNT_W-1:0]     tick_cnt_q;
   logic                 anim_done_q;

   // Position/flip latched once per video frame
   logic [9:0]           pos_x_q;
   logic [9:0]           pos_y_q;
   logic                 flip_q;

   // Pipeline registers
   logic [ADDR_W-1:0]    rom_address_q;
   logic [ADDR_W-1:0]    rom_address_d;
   logic                 hit_q;
   logic                 hit_d;
   logic                 blank_q;
   logic [IDX_BITS-1:0]  pixel_index_q;
   logic                 pixel_valid_q;
   logic                 pixel_valid_d;

   // Stage-1 arithmetic, all 11-bit unsigned so sprites clip at the edges
   logic [10:0] draw_x_w;
   logic [10:0] draw_y_w;
   logic [10:0] pos_x_w;
   logic [10:0] pos_y_w;
   logic [10:0] x_end;
   logic [10:0] y_end;
   logic [10:0] dx;
   logic [10:0] dy;
   logic [10:0] col_raw;
   logic [10:0] col;
   logic [10:0] row;
   logic [ADDR_W-1:0] addr_calc;

   // Hit test and texel address for the pixel currently on DrawX/DrawY
   always_comb begin
      draw_x_w      = {1'b0, DrawX};
      draw_y_w      = {1'b0, DrawY};
      pos_x_w       = {1'b0, pos_x_q};
      pos_y_w       = {1'b0, pos_y_q};
      x_end         = pos_x_w + SPAN_X;
      y_end         = pos_y_w + SPAN_Y;
      hit_d         = (draw_x_w >= pos_x_w) && (draw_x_w < x_end) &&
                      (draw_y_w >= pos_y_w) && (draw_y_w < y_end);
      dx            = draw_x_w - pos_x_w;
      dy            = draw_y_w - pos_y_w;
      col_raw       = dx >> SCALE_LOG2;
      col           = flip_q ? (COL_MAX - col_raw) : col_raw;
      row           = dy >> SCALE_LOG2;
      addr_calc     = ADDR_W'(anim_frame_q) * FRAME_SIZE_A
                    + ADDR_W'(row) * SPR_W_A
                    + ADDR_W'(col);
      // Outside the sprite the ROM address is left alone to avoid needless toggling
      rom_address_d = hit_d ? addr_calc : rom_address_q;
      pixel_valid_d = hit_q & blank_q & (rom_q != TRANS_IDX);
   end

   // Latch sprite placement at vertical blanking so a frame never tears
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         pos_x_q <= '0;
         pos_y_q <= '0;
         flip_q  <= 1'b0;
      end else if (frame_tick) begin
         pos_x_q <= pos_x;
         pos_y_q <= pos_y;
         flip_q  <= flip_x;
      end
   end

   // Two-stage pixel pipeline: address/hit/blank, then ROM data capture
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         rom_address_q <= '0;
         hit_q         <= 1'b0;
         blank_q       <= 1'b0;
         pixel_index_q <= '0;
         pixel_valid_q <= 1'b0;
      end else begin
         rom_address_q <= rom_address_d;
         hit_q         <= hit_d;
         blank_q       <= blank;
         pixel_index_q <= rom_q;
         pixel_valid_q <= pixel_valid_d;
      end
   end

   // Animation FSM: trigger restarts from frame 0 and beats any advance
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         anim_frame_q <= '0;
         tick_cnt_q   <= '0;
         anim_done_q  <= 1'b0;
      end else begin
         anim_done_q <= 1'b0;
         if (trigger) begin
            state_q      <= ST_PLAY;
            anim_frame_q <= '0;
            tick_cnt_q   <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  anim_frame_q <= '0;
                  tick_cnt_q   <= '0;
               end
               ST_PLAY: begin
                  if (frame_tick) begin
                     if (tick_cnt_q == LAST_TICK) begin
                        tick_cnt_q <= '0;
                        if (anim_frame_q == LAST_FRAME) begin
                           if (loop_en) begin
                              anim_frame_q <= '0;
                           end else begin
                              state_q     <= ST_HOLD;
                              anim_done_q <= 1'b1;
                           end
                        end else begin
                           anim_frame_q <= anim_frame_q + 1'b1;
                        end
                     end else begin
                        tick_cnt_q <= tick_cnt_q + 1'b1;
                     end
                  end
               end
               ST_HOLD: begin
                  tick_cnt_q <= '0;
               end
               default: begin
                  state_q      <= ST_IDLE;
                  anim_frame_q <= '0;
                  tick_cnt_q   <= '0;
               end
            endcase
         end
      end
   end

   assign rom_address = rom_address_q;
   assign pixel_index = pixel_index_q;
   assign pixel_valid = pixel_valid_q;
   assign anim_frame  = anim_frame_q;
   assign anim_done   = anim_done_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Bench for sprite_anim_renderer: a default instance (scale 1x) and a 2x
// instance share stimulus. Pixel expectations go through a scoreboard;
// animation state is checked directly after each frame tick.
module tb_sprite_anim_renderer;

   logic        vga_clk = 1'b0;
   logic        reset;
   logic [9:0]  DrawX, DrawY, pos_x, pos_y;
   logic        blank, frame_tick, flip_x, trigger, loop_en;

   logic [15:0] rom_address0, rom_address1;
   logic [2:0]  rom_q0, rom_q1, pixel_index0, pixel_index1;
   logic        pixel_valid0, pixel_valid1, anim_done0, anim_done1;
   logic [1:0]  anim_frame0, anim_frame1, dbg_state0, dbg_state1;

   typedef struct {
      logic [15:0] a0;
      logic [15:0] a1;
      int          id;
   } addr_exp_t;

   typedef struct {
      logic        v;
      logic [2:0]  idx;
      int          id;
   } pix_exp_t;

   addr_exp_t addr_q[$];
   pix_exp_t  pix_q[$];

   int   n_cmp  = 0;
   int   n_err  = 0;
   int   pix_id = 0;
   logic iss    = 1'b0;
   logic tok1   = 1'b0;
   logic tok2   = 1'b0;

   // ---------------- clock / DUTs ----------------
   always #5 vga_clk = ~vga_clk;

   // ROM contents: texel value is a fixed scramble of its address
   function automatic logic [2:0] rom_fn(input logic [15:0] a);
      return a[2:0] ^ a[5:3];
   endfunction

   assign rom_q0 = rom_fn(rom_address0);
   assign rom_q1 = rom_fn(rom_address1);

   sprite_anim_renderer u_dut0 (
      .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
      .blank(blank), .frame_tick(frame_tick), .pos_x(pos_x), .pos_y(pos_y),
      .flip_x(flip_x), .trigger(trigger), .loop_en(loop_en),
      .rom_address(rom_address0), .rom_q(rom_q0), .pixel_index(pixel_index0),
      .pixel_valid(pixel_valid0), .anim_frame(anim_frame0),
      .anim_done(anim_done0), .dbg_state(dbg_state0)
   );

   sprite_anim_renderer #(.SCALE_LOG2(1)) u_dut1 (
      .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
      .blank(blank), .frame_tick(frame_tick), .pos_x(pos_x), .pos_y(pos_y),
      .flip_x(flip_x), .trigger(trigger), .loop_en(loop_en),
      .rom_address(rom_address1), .rom_q(rom_q1), .pixel_index(pixel_index1),
      .pixel_valid(pixel_valid1), .anim_frame(anim_frame1),
      .anim_done(anim_done1), .dbg_state(dbg_state1)
   );

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Token pipeline marks which cycles carry a scored pixel
   always @(posedge vga_clk) begin
      tok1 <= iss;
      tok2 <= tok1;
   end

   // Monitor: pops expectations as the scored pixel reaches each stage
   always @(negedge vga_clk) begin
      addr_exp_t ea;
      pix_exp_t  ep;
      if (tok1) begin
         if (addr_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL addr_underflow: got empty queue expected entry");
         end else begin
            ea = addr_q.pop_front();
            check($sformatf("addr_1x#%0d", ea.id), rom_address0, ea.a0);
            check($sformatf("addr_2x#%0d", ea.id), rom_address1, ea.a1);
         end
      end
      if (tok2) begin
         if (pix_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL pix_underflow: got empty queue expected entry");
         end else begin
            ep = pix_q.pop_front();
            check($sformatf("valid#%0d", ep.id), pixel_valid0, ep.v);
            check($sformatf("index#%0d", ep.id), pixel_index0, ep.idx);
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic drive_px(input int x, input int y, input logic b,
                           input logic [15:0] a0, input logic [15:0] a1,
                           input logic v, input logic [2:0] idx);
      addr_exp_t ea;
      pix_exp_t  ep;
      @(negedge vga_clk);
      DrawX = 10'(x);
      DrawY = 10'(y);
      blank = b;
      iss   = 1'b1;
      ea.a0 = a0; ea.a1 = a1; ea.id = pix_id;
      ep.v  = v;  ep.idx = idx; ep.id = pix_id;
      addr_q.push_back(ea);
      pix_q.push_back(ep);
      pix_id++;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge vga_clk);
         iss   = 1'b0;
         blank = 1'b0;
      end
   endtask

   task automatic tick();
      @(negedge vga_clk);
      frame_tick = 1'b1;
      @(negedge vga_clk);
      frame_tick = 1'b0;
   endtask

   task automatic trig_pulse();
      @(negedge vga_clk);
      trigger = 1'b1;
      @(negedge vga_clk);
      trigger = 1'b0;
   endtask

   task automatic trig_tick();
      @(negedge vga_clk);
      trigger    = 1'b1;
      frame_tick = 1'b1;
      @(negedge vga_clk);
      trigger    = 1'b0;
      frame_tick = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_addr0"},  rom_address0, 0);
      check({tag, "_addr1"},  rom_address1, 0);
      check({tag, "_idx0"},   pixel_index0, 0);
      check({tag, "_idx1"},   pixel_index1, 0);
      check({tag, "_valid0"}, pixel_valid0, 0);
      check({tag, "_valid1"}, pixel_valid1, 0);
      check({tag, "_frame0"}, anim_frame0, 0);
      check({tag, "_frame1"}, anim_frame1, 0);
      check({tag, "_done0"},  anim_done0, 0);
      check({tag, "_done1"},  anim_done1, 0);
      check({tag, "_state0"}, dbg_state0, 0);
      check({tag, "_state1"}, dbg_state1, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b0; frame_tick = 1'b0;
      pos_x = '0; pos_y = '0; flip_x = 1'b0; trigger = 1'b0; loop_en = 1'b0;
      repeat (3) @(negedge vga_clk);
      check_reset_vals("rst");
      reset = 1'b0;
      idle(2);

      // Placement at (100,50), no flip
      pos_x = 10'd100; pos_y = 10'd50;
      tick();
      idle(1);
      drive_px(100, 50,  1'b1, 16'd0,     16'd0,    1'b0, 3'd0);
      drive_px(101, 50,  1'b1, 16'd1,     16'd0,    1'b1, 3'd1);
      drive_px(103, 50,  1'b1, 16'd3,     16'd1,    1'b1, 3'd3);
      drive_px(169, 50,  1'b1, 16'd69,    16'd34,   1'b1, 3'd5);
      drive_px(170, 50,  1'b1, 16'd69,    16'd35,   1'b0, 3'd5);
      drive_px(105, 52,  1'b0, 16'd145,   16'd72,   1'b0, 3'd3);
      drive_px(99,  50,  1'b1, 16'd145,   16'd72,   1'b0, 3'd3);
      drive_px(100, 49,  1'b1, 16'd145,   16'd72,   1'b0, 3'd3);
      drive_px(100, 209, 1'b1, 16'd11130, 16'd5530, 1'b1, 3'd5);
      drive_px(100, 210, 1'b1, 16'd11130, 16'd5600, 1'b0, 3'd5);
      idle(3);

      // Horizontal mirroring
      flip_x = 1'b1;
      tick();
      idle(1);
      drive_px(100, 51,  1'b1, 16'd139,   16'd69,   1'b1, 3'd2);
      drive_px(169, 50,  1'b1, 16'd0,     16'd35,   1'b0, 3'd0);
      idle(3);
      flip_x = 1'b0;
      tick();
      idle(1);

      // Mid-frame position change stays invisible until the next tick
      pos_x = 10'd200;
      drive_px(101, 50,  1'b1, 16'd1,     16'd0,    1'b1, 3'd1);
      drive_px(200, 50,  1'b1, 16'd1,     16'd50,   1'b0, 3'd1);
      idle(3);
      tick();
      idle(1);
      drive_px(201, 50,  1'b1, 16'd1,     16'd0,    1'b1, 3'd1);
      drive_px(101, 50,  1'b1, 16'd1,     16'd0,    1'b0, 3'd1);
      idle(3);

      // One-shot animation, frame 2 rendered at (0,0)
      loop_en = 1'b0;
      trig_pulse();
      check("trig_frame", anim_frame0, 0);
      check("trig_state", dbg_state0, 1);
      for (int t = 1; t <= 24; t++) begin
         tick();
         check($sformatf("once_frame_t%0d", t), anim_frame0, (t < 24) ? (t / 6) : 3);
         check($sformatf("once_done_t%0d", t), anim_done0, (t == 24) ? 1 : 0);
         if (t == 12) begin
            pos_x = 10'd0;
            pos_y = 10'd0;
         end
         if (t == 13) begin
            drive_px(0, 0, 1'b1, 16'd22400, 16'd22400, 1'b0, 3'd0);
            drive_px(1, 0, 1'b1, 16'd22401, 16'd22400, 1'b1, 3'd1);
            idle(3);
         end
      end
      check("hold_state", dbg_state0, 2);
      check("hold_frame_2x", anim_frame1, 3);
      tick();
      check("hold_frame_after", anim_frame0, 3);
      check("hold_done_after", anim_done0, 0);

      // Looping animation
      loop_en = 1'b1;
      trig_pulse();
      check("loop_start", anim_frame0, 0);
      for (int t = 1; t <= 24; t++) begin
         tick();
         check($sformatf("loop_frame_t%0d", t), anim_frame0, (t / 6) % 4);
         check($sformatf("loop_done_t%0d", t), anim_done0, 0);
      end
      check("loop_state", dbg_state0, 1);

      // Trigger beats a simultaneous advancing tick and clears the counter
      repeat (6) tick();
      check("pre_trig_frame", anim_frame0, 1);
      repeat (5) tick();
      check("pre_trig_frame2", anim_frame0, 1);
      trig_tick();
      check("coinc_frame", anim_frame0, 0);
      check("coinc_state", dbg_state0, 1);
      repeat (5) tick();
      check("coinc_cnt5", anim_frame0, 0);
      tick();
      check("coinc_cnt6", anim_frame0, 1);

      // Trigger on the final advance of a one-shot suppresses anim_done
      loop_en = 1'b0;
      trig_pulse();
      repeat (23) tick();
      check("last_frame", anim_frame0, 3);
      trig_tick();
      check("supp_done", anim_done0, 0);
      check("supp_frame", anim_frame0, 0);
      check("supp_state", dbg_state0, 1);

      // Asynchronous reset during PLAY at frame 2 with an opaque pixel showing
      trig_pulse();
      repeat (12) tick();
      check("pre_rst_frame", anim_frame0, 2);
      @(negedge vga_clk);
      DrawX = 10'd1; DrawY = 10'd0; blank = 1'b1;
      repeat (2) @(negedge vga_clk);
      check("pre_rst_addr", rom_address0, 22401);
      check("pre_rst_valid", pixel_valid0, 1);
      #2 reset = 1'b1;
      #1 check_reset_vals("async");
      @(negedge vga_clk);
      reset = 1'b0;
      blank = 1'b0;
      idle(2);

      check("sb_empty", addr_q.size() + pix_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
